// File: rtl/iwrr_grant_mux.sv
// Consumer side of the IWRR arbiter grant handshake: moves one granted burst into a single
// registered output stream and reports the beat count. IWRR_GMUX_LAST_EN adds s_last_i burst end.
module iwrr_grant_mux #(
  parameter int unsigned P_REQUESTER_NUM = 3,
  parameter int unsigned P_DATA_W        = 32,
  parameter int unsigned P_WEIGHT_W      = 3,
  parameter int unsigned P_BURST_MAX     = 4,
  localparam int unsigned SrcW = (P_REQUESTER_NUM > 1) ? $clog2(P_REQUESTER_NUM) : 1
) (
  input  logic                                clk,
  input  logic                                rst_n,
  input  logic [P_REQUESTER_NUM-1:0]          s_valid_i,
  input  logic [P_REQUESTER_NUM*P_DATA_W-1:0] s_data_i,
  input  logic [P_REQUESTER_NUM-1:0]          s_last_i,
  output logic [P_REQUESTER_NUM-1:0]          s_ready_o,
  output logic [P_REQUESTER_NUM-1:0]          req_o,
  input  logic [P_REQUESTER_NUM-1:0]          grant_valid_i,
  output logic                                grant_ready_o,
  output logic [P_WEIGHT_W-1:0]               num_grant_o,
  output logic                                m_valid_o,
  output logic [P_DATA_W-1:0]                 m_data_o,
  output logic [SrcW-1:0]                     m_src_o,
`ifdef IWRR_GMUX_LAST_EN
  output logic                                m_last_o,
`endif
  input  logic                                m_ready_i
);

  typedef enum logic [1:0] {StIdle, StXfer, StRelease} state_e;

  localparam logic [P_WEIGHT_W-1:0] BurstMax = P_WEIGHT_W'(P_BURST_MAX);

  state_e                state_q, state_d;
  logic [SrcW-1:0]       sel_q, sel_d, grant_idx;
  logic [P_WEIGHT_W-1:0] cnt_q, cnt_d, cnt_inc;
  logic                  out_free, accept, sel_valid, sel_last;

  assign req_o     = s_valid_i;
  assign out_free  = ~m_valid_o | m_ready_i;
  assign sel_valid = s_valid_i[sel_q];
  assign accept    = (state_q == StXfer) & sel_valid & out_free;
  assign cnt_inc   = cnt_q + 1'b1;

`ifdef IWRR_GMUX_LAST_EN
  assign sel_last = s_last_i[sel_q];
`else
  logic unused_last;
  assign sel_last    = 1'b0;
  assign unused_last = ^s_last_i;
`endif

  // Lowest set bit wins; a multi-hot grant is illegal but must still resolve deterministically.
  always_comb begin
    grant_idx = '0;
    for (int i = int'(P_REQUESTER_NUM) - 1; i >= 0; i--) begin
      if (grant_valid_i[i]) grant_idx = SrcW'(i);
    end
  end

  always_comb begin
    s_ready_o = '0;
    if (state_q == StXfer) s_ready_o[sel_q] = out_free;
  end

  always_comb begin
    state_d = state_q;
    sel_d   = sel_q;
    cnt_d   = cnt_q;
    case (state_q)
      StIdle: begin
        if (|grant_valid_i) begin
          sel_d   = grant_idx;
          cnt_d   = '0;
          state_d = StXfer;
        end
      end
      StXfer: begin
        if (accept) begin
          cnt_d = cnt_inc;
          if (cnt_inc == BurstMax || sel_last) state_d = StRelease;
        end else if (cnt_q != '0 && !sel_valid) begin
          state_d = StRelease;
        end
      end
      StRelease: state_d = StIdle;
      default:   state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q       <= StIdle;
      sel_q         <= '0;
      cnt_q         <= '0;
      grant_ready_o <= 1'b0;
      num_grant_o   <= '0;
      m_valid_o     <= 1'b0;
      m_data_o      <= '0;
      m_src_o       <= '0;
`ifdef IWRR_GMUX_LAST_EN
      m_last_o      <= 1'b0;
`endif
    end else begin
      state_q       <= state_d;
      sel_q         <= sel_d;
      cnt_q         <= cnt_d;
      // Registered so the pulse and count line up exactly with the RELEASE cycle.
      grant_ready_o <= (state_d == StRelease);
      num_grant_o   <= (state_d == StRelease) ? cnt_d : '0;
      if (accept) begin
        m_valid_o <= 1'b1;
        m_data_o  <= s_data_i[sel_q*P_DATA_W +: P_DATA_W];
        m_src_o   <= sel_q;
`ifdef IWRR_GMUX_LAST_EN
        m_last_o  <= sel_last;
`endif
      end else if (m_ready_i) begin
        m_valid_o <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_iwrr_grant_mux.sv
// Scoreboard bench for iwrr_grant_mux: per-requester word queues feed the DUT, expected beats
// and burst counts are queued at load time and popped as the output side produces them.
module tb_iwrr_grant_mux;

  localparam int unsigned N  = 3;
  localparam int unsigned DW = 32;
  localparam int unsigned WW = 3;
`ifdef IWRR_GMUX_LAST_EN
  localparam bit LastEn = 1'b1;
`else
  localparam bit LastEn = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst_n;
  logic [N-1:0]  s_valid_i, s_last_i, s_ready_o, req_o, grant_valid_i;
  logic [N*DW-1:0] s_data_i;
  logic          grant_ready_o;
  logic [WW-1:0] num_grant_o;
  logic          m_valid_o;
  logic [DW-1:0] m_data_o;
  logic [1:0]    m_src_o;
  logic          m_ready_i;
  logic          m_last;

`ifdef IWRR_GMUX_LAST_EN
  logic m_last_o;
  assign m_last = m_last_o;
`else
  assign m_last = 1'b0;
`endif

  iwrr_grant_mux #(
    .P_REQUESTER_NUM(N),
    .P_DATA_W       (DW),
    .P_WEIGHT_W     (WW),
    .P_BURST_MAX    (4)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .s_valid_i    (s_valid_i),
    .s_data_i     (s_data_i),
    .s_last_i     (s_last_i),
    .s_ready_o    (s_ready_o),
    .req_o        (req_o),
    .grant_valid_i(grant_valid_i),
    .grant_ready_o(grant_ready_o),
    .num_grant_o  (num_grant_o),
    .m_valid_o    (m_valid_o),
    .m_data_o     (m_data_o),
    .m_src_o      (m_src_o),
`ifdef IWRR_GMUX_LAST_EN
    .m_last_o     (m_last_o),
`endif
    .m_ready_i    (m_ready_i)
  );

  always #5 clk = ~clk;

  logic [32:0]   src0_q[$], src1_q[$], src2_q[$];  // {last, data}
  logic [2:0]    gnt_q[$];
  logic          rdy_q[$];
  logic [34:0]   exp_beat_q[$];                     // {src, last, data}
  logic [WW-1:0] exp_num_q[$];
  int unsigned   n_checks = 0, n_fail = 0, releases = 0;
  logic [N-1:0]  hs;
  logic          rel_seen;
  logic          rdy_cur;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic int qsize(input int i);
    case (i)
      0:       return src0_q.size();
      1:       return src1_q.size();
      default: return src2_q.size();
    endcase
  endfunction

  function automatic logic [32:0] qfront(input int i);
    case (i)
      0:       return src0_q[0];
      1:       return src1_q[0];
      default: return src2_q[0];
    endcase
  endfunction

  task automatic qpush(input int i, input logic [32:0] w);
    case (i)
      0:       src0_q.push_back(w);
      1:       src1_q.push_back(w);
      default: src2_q.push_back(w);
    endcase
  endtask

  task automatic qpop(input int i);
    case (i)
      0:       void'(src0_q.pop_front());
      1:       void'(src1_q.pop_front());
      default: void'(src2_q.pop_front());
    endcase
  endtask

  task automatic qflush(input int i);
    while (qsize(i) != 0) qpop(i);
  endtask

  task automatic drive();
    logic [32:0] w;
    for (int i = 0; i < int'(N); i++) begin
      w = (qsize(i) != 0) ? qfront(i) : '0;
      s_valid_i[i]         = (qsize(i) != 0);
      s_last_i[i]          = w[32];
      s_data_i[i*DW +: DW] = w[31:0];
    end
    grant_valid_i = (gnt_q.size() != 0) ? gnt_q[0] : '0;
    m_ready_i     = rdy_cur;
  endtask

  // Queue n words on requester i; the first exp_n of them are expected on the output.
  task automatic load(input int i, input int n, input logic [31:0] base, input int last_k,
                      input int exp_n);
    logic lst;
    for (int k = 0; k < n; k++) begin
      lst = (k == last_k);
      qpush(i, {lst, base + 32'(k)});
      if (k < exp_n) exp_beat_q.push_back({2'(i), lst & LastEn, base + 32'(k)});
    end
    if (exp_n > 0) exp_num_q.push_back(WW'(exp_n));
  endtask

  task automatic sample();
    logic [34:0]   e;
    logic [WW-1:0] en;
    @(negedge clk);
    hs       = s_valid_i & s_ready_o;
    rel_seen = grant_ready_o;
    check_eq("req_o", 64'(req_o), 64'(s_valid_i));
    if (m_valid_o && m_ready_i) begin
      if (exp_beat_q.size() == 0) begin
        check_eq("beat_extra", 64'(exp_beat_q.size()), 1);
      end else begin
        e = exp_beat_q.pop_front();
        check_eq("beat", 64'({m_src_o, m_last, m_data_o}), 64'(e));
      end
    end
    if (m_valid_o && !m_ready_i) check_eq("bp_sready", 64'(s_ready_o), 0);
    if (grant_ready_o) begin
      releases++;
      if (exp_num_q.size() == 0) begin
        check_eq("num_extra", 64'(exp_num_q.size()), 1);
      end else begin
        en = exp_num_q.pop_front();
        check_eq("num_grant", 64'(num_grant_o), 64'(en));
      end
    end else begin
      check_eq("num_idle", 64'(num_grant_o), 0);
    end
  endtask

  task automatic advance();
    @(posedge clk);
    #1;
    for (int i = 0; i < int'(N); i++) if (hs[i]) qpop(i);
    // Arbiter model: the grant is retired by the consumed pulse.
    if (rel_seen && gnt_q.size() != 0) void'(gnt_q.pop_front());
    if (rdy_q.size() != 0) rdy_cur = rdy_q.pop_front();
    else rdy_cur = 1'b1;
    drive();
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      sample();
      advance();
    end
  endtask

  task automatic wait_release(input string tag, input int budget);
    int unsigned start;
    int          c;
    start = releases;
    c     = 0;
    while (releases == start && c < budget) begin
      sample();
      advance();
      c++;
    end
    check_eq(tag, 64'(releases - start), 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    rst_n   = 1'b0;
    rdy_cur = 1'b1;
    hs      = '0;
    rel_seen = 1'b0;
    // Reset with grant 010 and all requesters valid; nothing may move until reset drops.
    load(0, 1, 32'h0A00_0000, -1, 0);
    load(1, 4, 32'h1100_0000, -1, 4);
    load(2, 1, 32'h0C00_0000, -1, 0);
    gnt_q.push_back(3'b010);
    drive();
    @(posedge clk);
    #1;
    repeat (3) begin
      sample();
      check_eq("rst_m_valid", 64'(m_valid_o), 0);
      check_eq("rst_grant_ready", 64'(grant_ready_o), 0);
      check_eq("rst_s_ready", 64'(s_ready_o), 0);
      advance();
    end
    rst_n = 1'b1;
    sample();
    check_eq("idle_s_ready", 64'(s_ready_o), 0);
    advance();
    sample();
    check_eq("first_s_ready", 64'(s_ready_o), 64'(3'b010));
    check_eq("first_m_valid", 64'(m_valid_o), 0);
    advance();
    wait_release("rel_reset", 20);
    idle(3);
    qflush(0);
    qflush(2);
    drive();

    // Full burst: more words than the burst limit.
    load(0, 6, 32'hF000_0000, -1, 4);
    gnt_q.push_back(3'b001);
    drive();
    wait_release("rel_full", 30);
    idle(3);
    qflush(0);
    drive();

    // Requester runs dry after two beats.
    load(1, 2, 32'h2200_0000, -1, 2);
    gnt_q.push_back(3'b010);
    drive();
    wait_release("rel_dry", 30);
    idle(3);

    // Downstream backpressure during a 4-beat burst.
    load(0, 4, 32'h3300_0000, -1, 4);
    foreach (rdy_q[k]) rdy_q.delete(k);
    rdy_q.push_back(1'b1); rdy_q.push_back(1'b0); rdy_q.push_back(1'b0); rdy_q.push_back(1'b1);
    rdy_q.push_back(1'b0); rdy_q.push_back(1'b0); rdy_q.push_back(1'b1); rdy_q.push_back(1'b0);
    gnt_q.push_back(3'b001);
    drive();
    wait_release("rel_bp", 40);
    idle(4);

    // Grant switches to requester 2 mid-burst; two entries so one survives the first release.
    load(0, 4, 32'h4400_0000, -1, 4);
    load(2, 3, 32'h5500_0000, -1, 3);
    gnt_q.push_back(3'b001);
    drive();
    idle(2);
    gnt_q.delete();
    gnt_q.push_back(3'b100);
    gnt_q.push_back(3'b100);
    drive();
    wait_release("rel_mid0", 30);
    wait_release("rel_mid2", 30);
    idle(3);

`ifdef IWRR_GMUX_LAST_EN
    load(0, 4, 32'h6600_0000, 1, 2);
    gnt_q.push_back(3'b001);
    drive();
    wait_release("rel_last", 30);
    idle(3);
    qflush(0);
    drive();
`endif

    check_eq("sb_beats_left", 64'(exp_beat_q.size()), 0);
    check_eq("sb_num_left", 64'(exp_num_q.size()), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/iwrr_grant_mux.md
Name: iwrr_grant_mux

Overview:
- Consumer end of the IWRR arbiter grant handshake.
- Presents per-requester stream valids as arbiter requests and latches the one-hot grant.
- Moves a burst of beats from the granted requester to a single registered output stream.
- On burst end, returns a one-cycle grant_ready pulse together with the consumed-beat count, so the arbiter advances its pointer and decrements weight.

Parameters:
- P_REQUESTER_NUM, 3, number of requester streams (≥2)
- P_DATA_W, 32, payload width per beat
- P_WEIGHT_W, 3, width of num_grant_o; must match the arbiter weight width
- P_BURST_MAX, 4, maximum beats per grant (1..2^P_WEIGHT_W-1)

Ports:
- clk  in  1  clock
- rst_n  in  1  synchronous, active-low reset
- s_valid_i  in  P_REQUESTER_NUM  per-requester beat valid
- s_data_i  in  P_REQUESTER_NUM*P_DATA_W  per-requester payload; requester i occupies bits [i*P_DATA_W +: P_DATA_W]
- s_last_i  in  P_REQUESTER_NUM  per-requester end-of-burst marker; used only with the optional feature
- s_ready_o  out  P_REQUESTER_NUM  per-requester beat accept
- req_o  out  P_REQUESTER_NUM  request vector to the arbiter; equals s_valid_i (combinational)
- grant_valid_i  in  P_REQUESTER_NUM  one-hot grant from the arbiter
- grant_ready_o  out  1  grant consumed; one-cycle pulse
- num_grant_o  out  P_WEIGHT_W  beats transferred in the finished burst; valid only while grant_ready_o=1, otherwise 0
- m_valid_o  out  1  registered output valid
- m_data_o  out  P_DATA_W  registered output data
- m_src_o  out  clog2(P_REQUESTER_NUM)  index of the source requester for the current output beat
- m_ready_i  in  1  downstream accept

Behaviour:
- Reset values: state IDLE, sel_r=0, cnt_r=0, m_valid_o=0, m_data_o=0, m_src_o=0, grant_ready_o=0, num_grant_o=0, s_ready_o=0.
- Reset mid-burst: any beat held in the output register is dropped; the arbiter is reset by the same rst_n.
- Requester rule: once s_valid_i[i]=1, it stays high until accepted.
- Output stage: one register slice. out_free = ~m_valid_o | m_ready_i.
- A beat is accepted when state=XFER, s_valid_i[sel_r]=1 and out_free=1.
  - s_ready_o[sel_r] = out_free in XFER; all other s_ready_o bits are 0.
  - On accept: m_valid_o<=1, m_data_o<=s_data_i[sel_r], m_src_o<=sel_r, cnt_r<=cnt_r+1.
  - Otherwise, if m_ready_i=1: m_valid_o<=0.
- FSM:
  - IDLE:
    - If |grant_valid_i: sel_r<=index of the lowest set bit; cnt_r<=0; go to XFER.
    - Multi-hot grant takes the lowest set bit; this is illegal input.
    - The grant is sampled only in IDLE.
  - XFER: the burst ends in the cycle where any of the following holds; then go to RELEASE.
    - An accepted beat makes cnt_r+1 == P_BURST_MAX.
    - cnt_r ≥ 1 and s_valid_i[sel_r]=0 (requester ran dry).
  - RELEASE:
    - grant_ready_o=1 and num_grant_o=cnt_r, both registered outputs asserted for exactly this one cycle; then go to IDLE.
    - No beat is accepted in RELEASE.
- Latency:
  - Grant seen in IDLE at cycle t → first s_ready_o possible at t+1 → data on m_data_o at t+2.
  - Minimum one IDLE cycle between RELEASE and the next XFER, so the arbiter's updated grant is sampled.
- cnt_r width is P_WEIGHT_W; it never exceeds P_BURST_MAX, so it cannot wrap.
- Backpressure (m_ready_i=0 with m_valid_o=1) stalls XFER indefinitely; the burst count is not affected.

Optional Feature:
- Macro IWRR_GMUX_LAST_EN.
- When defined: an accepted beat with s_last_i[sel_r]=1 also ends the burst (XFER→RELEASE), and m_last_o (out, 1, registered) is added, carrying the accepted s_last_i.
- When undefined: s_last_i is ignored, there is no m_last_o, and bursts end only on P_BURST_MAX or a dry requester.

Test Plan:
- Reset: hold rst_n=0 for 3 cycles, with grant_valid_i=3'b010 and all s_valid_i=1 → m_valid_o=0, grant_ready_o=0, s_ready_o=0 throughout; FSM goes to XFER only after release of reset.
- Full burst: s_valid_i=3'b001 continuously, grant 3'b001, m_ready_i=1 → 4 beats with m_src_o=0, then a one-cycle grant_ready_o with num_grant_o=4.
- Dry requester: requester 1 presents 2 beats then drops valid, grant 3'b010 → num_grant_o=2 and m_data_o sequence matches the 2 input words.
- Backpressure: m_ready_i toggles 1,0,0,1 during a 4-beat burst → no beat lost or duplicated; s_ready_o[sel] low while the output register is full and m_ready_i=0.
- Grant change mid-burst: grant_valid_i switches from 3'b001 to 3'b100 during XFER → transfer continues from requester 0 until burst end; requester 2 is served only after RELEASE+IDLE.
- With IWRR_GMUX_LAST_EN: s_last_i[0]=1 on the 2nd beat → m_last_o=1 on that beat, num_grant_o=2.
